nvme_sq_fetch: RTL and testbench
================================

// Module: nvme_sq_fetch
// PURPOSE
// Controller-side Submission Queue fetch engine; the reader counterpart of nvme_cq, which writes completions.
// - Accepts host SQ tail doorbells and tracks per-queue head/tail.
// - Fetches 64-byte commands from host memory over the PCIe read interface.
// - Delivers commands to the command processor with valid/ready.
// - Exposes each new SQ head, which nvme_cq places in completion entries.
// PARAMETERS
// SQ_COUNT  2   number of Submission Queues
// SQ_DEPTH  64  entries per queue; power of two, >=2; PTR_W = $clog2(SQ_DEPTH)
// PORTS
// clk             in   1             clock
// reset           in   1             asynchronous, active-high reset
// sq_enable       in   SQ_COUNT      per-queue enable
// sq_base         in   64*SQ_COUNT   queue base address; queue i = bits [64*i+63:64*i]
// sq_dbell_valid  in   1             tail doorbell write strobe
// sq_dbell_id     in   32            SQ id of the doorbell
// sq_dbell_ptr    in   32            new tail value
// sq_dbell_ack    out  1             doorbell accepted (pulse)
// sq_dbell_err    out  1             doorbell rejected (pulse)
// sq_read_req     out  1             read request to PCIe
// sq_read_addr    out  64            read address (64 bytes)
// sq_read_id      out  32            SQ id of the request
// sq_read_ack     in   1             PCIe accepted the request
// sq_rdata_valid  in   1             read data returned (1 cycle)
// sq_rdata        in   512           returned 64-byte command
// cmd_valid       out  1             command available
// cmd_data        out  512           command
// cmd_sq_id       out  32            source SQ id
// cmd_sq_head     out  32            SQ head after this command (zero-extended)
// cmd_ready       in   1             consumer accepts the command
// sq_empty        out  SQ_COUNT      head==tail per queue
// BEHAVIOUR
// - Reset: all outputs 0 except sq_empty=all ones; head/tail=0; FSM IDLE; round-robin pointer=0.
// - Doorbell, sampled when sq_dbell_valid=1:
//   - Valid when sq_dbell_id<SQ_COUNT, sq_enable[id]=1 and sq_dbell_ptr<SQ_DEPTH.
//   - Valid: tail[id] <= ptr[PTR_W-1:0] on that edge; sq_dbell_ack=1 on the next cycle.
//   - Invalid: tail unchanged; sq_dbell_err=1 on the next cycle.
//   - Back-to-back doorbells are each handled; the last one wins on the same queue.
// - sq_enable[i]=0 holds head[i]=tail[i]=0, so sq_empty[i]=1.
// - FSM IDLE->REQ->WAIT->OUT->IDLE; one fetch outstanding.
//   - IDLE: round-robin select of an enabled non-empty queue, starting at rr pointer.
//     Go to REQ next cycle with addr = base + (head<<6), mod 2^64. rr pointer <= selected+1 (wraps).
//   - REQ: sq_read_req=1; addr and id held stable until sq_read_ack. The ack cycle goes to WAIT; req drops.
//   - WAIT: on sq_rdata_valid, capture sq_rdata, go to OUT. Data outside WAIT is ignored.
//   - OUT: cmd_valid=1; data, id and head held until cmd_ready. On the handshake edge:
//     head <= head+1, wrapping SQ_DEPTH-1 -> 0; go to IDLE.
//     cmd_sq_head shows the post-increment value while cmd_valid=1.
// - Latency: queue becomes non-empty -> sq_read_req is 2 cycles (IDLE select, REQ asserted).
//   rdata_valid -> cmd_valid is 1 cycle.
// - Doorbell and head increment on the same queue in the same cycle: both applied.
// - Queue disabled while its fetch is in flight:
//   - The fetch completes and the command is delivered.
//   - The head increment is suppressed; head stays 0.
// - Reset mid-fetch: immediate return to IDLE; outputs cleared; late rdata is ignored.
// - Tail written equal to head: queue is empty, no fetch. Tail wrap-around needs no special handling.
// TESTING
// - Single queue: base=0x1000, doorbell id0 ptr3.
//   -> 3 reads at 0x1000, 0x1040, 0x1080; cmd_sq_head 1, 2, 3; sq_empty[0]=1 after the third handshake.
// - Wrap: SQ_DEPTH=64, head=62, doorbell ptr1.
//   -> reads at entries 62, 63, 0; cmd_sq_head 63, 0, 1.
// - Round-robin: doorbells q0 ptr2 and q1 ptr2, both pending.
//   -> sq_read_id sequence 0, 1, 0, 1.
// - Bad doorbells: id=5; ptr=64; queue disabled.
//   -> sq_dbell_err pulses 1 cycle each; no tail change; no read_req.
// - Backpressure: sq_read_ack delayed 4 cycles; cmd_ready low 5 cycles.
//   -> addr, id, data and head held stable; exactly one head increment.
// - Reset in WAIT with rdata arriving after reset release.
//   -> no cmd_valid; all heads and tails 0.

Source files
------------

// File: rtl/nvme_sq_fetch.sv
// NVMe Submission Queue fetch engine: tracks per-queue head/tail from host tail doorbells,
// fetches one 64-byte command at a time over PCIe and hands it to the command processor.
module nvme_sq_fetch #(
  parameter int SQ_COUNT = 2,
  parameter int SQ_DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SQ_COUNT-1:0]    sq_enable,
  input  logic [64*SQ_COUNT-1:0] sq_base,
  input  logic                   sq_dbell_valid,
  input  logic [31:0]            sq_dbell_id,
  input  logic [31:0]            sq_dbell_ptr,
  output logic                   sq_dbell_ack,
  output logic                   sq_dbell_err,
  output logic                   sq_read_req,
  output logic [63:0]            sq_read_addr,
  output logic [31:0]            sq_read_id,
  input  logic                   sq_read_ack,
  input  logic                   sq_rdata_valid,
  input  logic [511:0]           sq_rdata,
  output logic                   cmd_valid,
  output logic [511:0]           cmd_data,
  output logic [31:0]            cmd_sq_id,
  output logic [31:0]            cmd_sq_head,
  input  logic                   cmd_ready,
  output logic [SQ_COUNT-1:0]    sq_empty,
  output logic [1:0]             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where the producer's req/valid and the
  // consumer's ack/ready are both high; the producer holds its payload stable until that edge.

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int ID_W  = (SQ_COUNT > 1) ? $clog2(SQ_COUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0] head_q [SQ_COUNT];
  logic [PTR_W-1:0] tail_q [SQ_COUNT];
  logic [ID_W-1:0]  rr_q;
  logic [ID_W-1:0]  sel_id_q;
  logic [63:0]      addr_q;
  logic [PTR_W-1:0] cmd_head_q;
  logic [511:0]     data_q;
  logic             dbell_ack_q;
  logic             dbell_err_q;

  logic [SQ_COUNT-1:0] dbell_hit;
  logic                dbell_ok;
  logic [SQ_COUNT-1:0] fetchable;
  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  logic [63:0]         pick_addr;
  logic                cmd_fire;

  // Doorbell decode: one-hot hit on the addressed queue when id, enable and pointer are all legal
  always_comb begin
    dbell_hit = '0;
    for (int i = 0; i < SQ_COUNT; i++) begin
      dbell_hit[i] = sq_dbell_valid && (sq_dbell_id == 32'(i)) && sq_enable[i] &&
                     (sq_dbell_ptr < 32'(SQ_DEPTH));
    end
  end

  assign dbell_ok = |dbell_hit;
  assign cmd_fire = (state == S_OUT) && cmd_ready;

  always_comb begin
    for (int i = 0; i < SQ_COUNT; i++) begin
      sq_empty[i]  = (head_q[i] == tail_q[i]);
      fetchable[i] = sq_enable[i] && (head_q[i] != tail_q[i]);
    end
  end

  // Round-robin pick: first fetchable queue at or after rr_q
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < SQ_COUNT; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= SQ_COUNT) idx = idx - SQ_COUNT;
      if (!pick_valid && fetchable[idx]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
    pick_addr = sq_base[64*int'(pick_id) +: 64] +
                {{(58-PTR_W){1'b0}}, head_q[pick_id], 6'b0};
  end

  // Per-queue pointers; a disabled queue is pinned empty at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SQ_COUNT; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SQ_COUNT; i++) begin
        if (!sq_enable[i]) begin
          head_q[i] <= '0;
          tail_q[i] <= '0;
        end else begin
          if (dbell_hit[i]) tail_q[i] <= sq_dbell_ptr[PTR_W-1:0];
          if (cmd_fire && (sel_id_q == ID_W'(i))) head_q[i] <= head_q[i] + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbell_ack_q <= 1'b0;
      dbell_err_q <= 1'b0;
    end else begin
      dbell_ack_q <= dbell_ok;
      dbell_err_q <= sq_dbell_valid && !dbell_ok;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_valid)     state_nxt = S_REQ;
      S_REQ:   if (sq_read_ack)    state_nxt = S_WAIT;
      S_WAIT:  if (sq_rdata_valid) state_nxt = S_OUT;
      S_OUT:   if (cmd_ready)      state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    sq_read_req = (state == S_REQ);
    cmd_valid   = (state == S_OUT);
    dbg_state   = state;
  end

  // Fetch context captured at selection, held through REQ/WAIT/OUT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_id_q   <= '0;
      addr_q     <= '0;
      cmd_head_q <= '0;
      data_q     <= '0;
      rr_q       <= '0;
    end else begin
      if ((state == S_IDLE) && pick_valid) begin
        sel_id_q   <= pick_id;
        addr_q     <= pick_addr;
        cmd_head_q <= head_q[pick_id] + PTR_W'(1);
        rr_q       <= (pick_id == ID_W'(SQ_COUNT-1)) ? '0 : pick_id + ID_W'(1);
      end
      if ((state == S_WAIT) && sq_rdata_valid) data_q <= sq_rdata;
    end
  end

  assign sq_dbell_ack = dbell_ack_q;
  assign sq_dbell_err = dbell_err_q;
  assign sq_read_addr = addr_q;
  assign sq_read_id   = 32'(sel_id_q);
  assign cmd_data     = data_q;
  assign cmd_sq_id    = 32'(sel_id_q);
  assign cmd_sq_head  = 32'(cmd_head_q);

endmodule

// File: tb/tb_nvme_sq_fetch.sv
// Directed bench for nvme_sq_fetch: doorbells, fetch sequencing, wrap, round-robin,
// backpressure, disable in flight and reset mid-fetch.
module tb_nvme_sq_fetch;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     sq_enable;
  logic [127:0]   sq_base;
  logic           sq_dbell_valid;
  logic [31:0]    sq_dbell_id;
  logic [31:0]    sq_dbell_ptr;
  logic           sq_dbell_ack;
  logic           sq_dbell_err;
  logic           sq_read_req;
  logic [63:0]    sq_read_addr;
  logic [31:0]    sq_read_id;
  logic           sq_read_ack;
  logic           sq_rdata_valid;
  logic [511:0]   sq_rdata;
  logic           cmd_valid;
  logic [511:0]   cmd_data;
  logic [31:0]    cmd_sq_id;
  logic [31:0]    cmd_sq_head;
  logic           cmd_ready;
  logic [1:0]     sq_empty;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [511:0] exp_q[$];

  localparam logic [63:0] BASE0 = 64'h0000_0000_0000_1000;
  localparam logic [63:0] BASE1 = 64'hFFFF_FFFF_FFFF_FFC0;

  nvme_sq_fetch #(.SQ_COUNT(2), .SQ_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .sq_enable(sq_enable), .sq_base(sq_base),
    .sq_dbell_valid(sq_dbell_valid), .sq_dbell_id(sq_dbell_id), .sq_dbell_ptr(sq_dbell_ptr),
    .sq_dbell_ack(sq_dbell_ack), .sq_dbell_err(sq_dbell_err),
    .sq_read_req(sq_read_req), .sq_read_addr(sq_read_addr), .sq_read_id(sq_read_id),
    .sq_read_ack(sq_read_ack), .sq_rdata_valid(sq_rdata_valid), .sq_rdata(sq_rdata),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_sq_id(cmd_sq_id),
    .cmd_sq_head(cmd_sq_head), .cmd_ready(cmd_ready), .sq_empty(sq_empty),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic doorbell(input int id, input int ptr, output logic ack, output logic err);
    @(negedge clk);
    sq_dbell_valid = 1'b1;
    sq_dbell_id    = 32'(id);
    sq_dbell_ptr   = 32'(ptr);
    @(negedge clk);
    sq_dbell_valid = 1'b0;
    ack = sq_dbell_ack;
    err = sq_dbell_err;
  endtask

  task automatic serve(input int ack_dly, input int rdy_dly, input logic [511:0] payload,
                       output logic [63:0] addr, output logic [31:0] id,
                       output logic [511:0] data, output logic [31:0] head,
                       output int waited, output logic stable, output logic ok);
    ok = 1'b1; stable = 1'b1; waited = 0;
    addr = '0; id = '0; data = '0; head = '0;
    while (!sq_read_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!sq_read_req) begin
      ok = 1'b0;
      return;
    end
    addr = sq_read_addr;
    id   = sq_read_id;
    repeat (ack_dly) begin
      @(negedge clk);
      if (!sq_read_req || sq_read_addr !== addr || sq_read_id !== id) stable = 1'b0;
    end
    sq_read_ack = 1'b1;
    @(negedge clk);
    sq_read_ack = 1'b0;
    if (sq_read_req !== 1'b0) ok = 1'b0;
    sq_rdata_valid = 1'b1;
    sq_rdata       = payload;
    @(negedge clk);
    sq_rdata_valid = 1'b0;
    sq_rdata       = '0;
    if (cmd_valid !== 1'b1 || cmd_sq_id !== id) ok = 1'b0;
    data = cmd_data;
    head = cmd_sq_head;
    repeat (rdy_dly) begin
      @(negedge clk);
      if (!cmd_valid || cmd_data !== data || cmd_sq_id !== id || cmd_sq_head !== head)
        stable = 1'b0;
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    if (cmd_valid !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({sq_read_req, cmd_valid, sq_dbell_ack, sq_dbell_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {sq_read_req, cmd_valid, sq_dbell_ack, sq_dbell_err}); end
    n_checks++; if (sq_empty !== 2'b11) begin n_fail++; $display("FAIL reset_empty: got %b expected 11", sq_empty); end
    n_checks++; if (sq_read_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", sq_read_addr); end
    n_checks++; if ({sq_read_id, cmd_sq_id, cmd_sq_head} !== 96'h0) begin n_fail++; $display("FAIL reset_ids: got %h expected 0", {sq_read_id, cmd_sq_id, cmd_sq_head}); end
    n_checks++; if (cmd_data !== 512'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", cmd_data); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({sq_read_req, cmd_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_release_idle: got %b expected 00", {sq_read_req, cmd_valid}); end
  endtask

  task automatic test_single_queue;
    logic ack, err, ok, stable, quiet;
    logic [63:0] addr; logic [31:0] id, head; logic [511:0] data, pay, exp;
    int waited;
    doorbell(0, 3, ack, err);
    n_checks++; if ({ack, err} !== 2'b10) begin n_fail++; $display("FAIL single_dbell: got ack/err %b expected 10", {ack, err}); end
    for (int k = 0; k < 3; k++) begin
      pay = {16{32'hC0DE_0000 + 32'(k)}};
      exp_q.push_back(pay);
      serve(0, 0, pay, addr, id, data, head, waited, stable, ok);
      exp = exp_q.pop_front();
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_hs%0d: got %b expected 1", k, ok); end
      n_checks++; if (waited != 1) begin n_fail++; $display("FAIL single_latency%0d: got %0d expected 1", k, waited); end
      n_checks++; if (addr !== BASE0 + 64'(64*k)) begin n_fail++; $display("FAIL single_addr%0d: got %h expected %h", k, addr, BASE0 + 64'(64*k)); end
      n_checks++; if (id !== 32'd0) begin n_fail++; $display("FAIL single_id%0d: got %0d expected 0", k, id); end
      n_checks++; if (head !== 32'(k+1)) begin n_fail++; $display("FAIL single_head%0d: got %0d expected %0d", k, head, k+1); end
      n_checks++; if (data !== exp) begin n_fail++; $display("FAIL single_data%0d: got %h expected %h", k, data, exp); end
    end
    n_checks++; if (sq_empty !== 2'b11) begin n_fail++; $display("FAIL single_empty: got %b expected 11", sq_empty); end
    n_checks++; if (sq_dbell_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected 0", sq_dbell_ack); end
    quiet = 1'b1;
    repeat (6) begin @(negedge clk); if (sq_read_req) quiet = 1'b0; end
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL single_no_extra_req: got req seen, expected none"); end
  endtask

  task automatic test_wrap;
    logic ack, err, ok, stable;
    logic [63:0] addr, exp_addr; logic [31:0] id, head; logic [511:0] data;
    int waited, bad, entry;
    doorbell(0, 62, ack, err);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wrap_dbell62: got ack %b expected 1", ack); end
    bad = 0;
    for (int k = 3; k < 62; k++) begin
      serve(0, 0, {16{32'(k)}}, addr, id, data, head, waited, stable, ok);
      if (!ok || head !== 32'(k+1)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wrap_fill: got %0d bad fetches expected 0", bad); end
    doorbell(0, 1, ack, err);
    n_checks++; if ({ack, err} !== 2'b10) begin n_fail++; $display("FAIL wrap_dbell1: got ack/err %b expected 10", {ack, err}); end
    for (int k = 0; k < 3; k++) begin
      entry = (62 + k) % 64;
      exp_addr = BASE0 + 64'(entry * 64);
      serve(0, 0, {16{32'hABCD_0000 + 32'(k)}}, addr, id, data, head, waited, stable, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_hs%0d: got %b expected 1", k, ok); end
      n_checks++; if (addr !== exp_addr) begin n_fail++; $display("FAIL wrap_addr%0d: got %h expected %h", k, addr, exp_addr); end
      n_checks++; if (head !== 32'((entry + 1) % 64)) begin n_fail++; $display("FAIL wrap_head%0d: got %0d expected %0d", k, head, (entry + 1) % 64); end
    end
    n_checks++; if (sq_empty !== 2'b11) begin n_fail++; $display("FAIL wrap_empty: got %b expected 11", sq_empty); end
  endtask

  task automatic test_round_robin;
    logic ack0, err0, ack1, err1, ok, stable;
    logic [63:0] addr; logic [31:0] id, head; logic [511:0] data;
    int waited;
    logic [63:0] exp_addr [4];
    int exp_id [4];
    int exp_head [4];
    exp_addr[0] = BASE0;         exp_id[0] = 0; exp_head[0] = 1;
    exp_addr[1] = BASE1;         exp_id[1] = 1; exp_head[1] = 1;
    exp_addr[2] = BASE0 + 64'h40; exp_id[2] = 0; exp_head[2] = 2;
    exp_addr[3] = 64'h0;         exp_id[3] = 1; exp_head[3] = 2;
    @(negedge clk); sq_enable = 2'b00;
    @(negedge clk); sq_enable = 2'b11;
    n_checks++; if (sq_empty !== 2'b11) begin n_fail++; $display("FAIL rr_disable_clears: got %b expected 11", sq_empty); end
    doorbell(0, 2, ack0, err0);
    doorbell(1, 2, ack1, err1);
    n_checks++; if ({ack0, err0, ack1, err1} !== 4'b1010) begin n_fail++; $display("FAIL rr_dbell: got %b expected 1010", {ack0, err0, ack1, err1}); end
    for (int k = 0; k < 4; k++) begin
      serve(0, 0, {16{32'h5151_0000 + 32'(k)}}, addr, id, data, head, waited, stable, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_hs%0d: got %b expected 1", k, ok); end
      n_checks++; if (id !== 32'(exp_id[k])) begin n_fail++; $display("FAIL rr_id%0d: got %0d expected %0d", k, id, exp_id[k]); end
      n_checks++; if (addr !== exp_addr[k]) begin n_fail++; $display("FAIL rr_addr%0d: got %h expected %h", k, addr, exp_addr[k]); end
      n_checks++; if (head !== 32'(exp_head[k])) begin n_fail++; $display("FAIL rr_head%0d: got %0d expected %0d", k, head, exp_head[k]); end
    end
  endtask

  task automatic test_bad_doorbells;
    logic ack, err, quiet;
    doorbell(5, 1, ack, err);
    n_checks++; if ({ack, err} !== 2'b01) begin n_fail++; $display("FAIL bad_id: got ack/err %b expected 01", {ack, err}); end
    @(negedge clk);
    n_checks++; if ({sq_dbell_ack, sq_dbell_err} !== 2'b00) begin n_fail++; $display("FAIL bad_err_pulse: got ack/err %b expected 00", {sq_dbell_ack, sq_dbell_err}); end
    doorbell(0, 64, ack, err);
    n_checks++; if ({ack, err} !== 2'b01) begin n_fail++; $display("FAIL bad_ptr: got ack/err %b expected 01", {ack, err}); end
    sq_enable = 2'b01;
    doorbell(1, 1, ack, err);
    n_checks++; if ({ack, err} !== 2'b01) begin n_fail++; $display("FAIL bad_disabled: got ack/err %b expected 01", {ack, err}); end
    quiet = 1'b1;
    repeat (8) begin @(negedge clk); if (sq_read_req) quiet = 1'b0; end
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL bad_no_req: got req seen, expected none"); end
    n_checks++; if (sq_empty !== 2'b11) begin n_fail++; $display("FAIL bad_tail_unchanged: got empty %b expected 11", sq_empty); end
    sq_enable = 2'b11;
  endtask

  task automatic test_back_to_back;
    logic a1, a2, ok, stable, quiet;
    logic [63:0] addr; logic [31:0] id, head; logic [511:0] data;
    int waited;
    logic [63:0] exp_addr [3];
    exp_addr[0] = BASE1; exp_addr[1] = 64'h0; exp_addr[2] = 64'h40;
    @(negedge clk);
    sq_dbell_valid = 1'b1; sq_dbell_id = 32'd1; sq_dbell_ptr = 32'd6;
    @(negedge clk);
    sq_dbell_ptr = 32'd3;
    a1 = sq_dbell_ack;
    @(negedge clk);
    sq_dbell_valid = 1'b0;
    a2 = sq_dbell_ack;
    n_checks++; if ({a1, a2} !== 2'b11) begin n_fail++; $display("FAIL b2b_acks: got %b expected 11", {a1, a2}); end
    for (int k = 0; k < 3; k++) begin
      serve(0, 0, {16{32'hB2B0_0000 + 32'(k)}}, addr, id, data, head, waited, stable, ok);
      n_checks++; if (ok !== 1'b1 || id !== 32'd1) begin n_fail++; $display("FAIL b2b_hs%0d: got ok %b id %0d expected ok 1 id 1", k, ok, id); end
      n_checks++; if (addr !== exp_addr[k] || head !== 32'(k+1)) begin n_fail++; $display("FAIL b2b_fetch%0d: got addr %h head %0d expected addr %h head %0d", k, addr, head, exp_addr[k], k+1); end
    end
    quiet = 1'b1;
    repeat (8) begin @(negedge clk); if (sq_read_req) quiet = 1'b0; end
    n_checks++; if (quiet !== 1'b1 || sq_empty !== 2'b11) begin n_fail++; $display("FAIL b2b_last_wins: got quiet %b empty %b expected 1 11", quiet, sq_empty); end
  endtask

  task automatic test_backpressure;
    logic ack, err, ok, stable;
    logic [63:0] addr; logic [31:0] id, head; logic [511:0] data, pay, exp;
    int waited;
    doorbell(0, 3, ack, err);
    pay = {8{64'hDEAD_BEEF_0000_0003}};
    exp_q.push_back(pay);
    serve(4, 5, pay, addr, id, data, head, waited, stable, ok);
    exp = exp_q.pop_front();
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_hs: got %b expected 1", ok); end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b expected 1", stable); end
    n_checks++; if (addr !== BASE0 + 64'h80) begin n_fail++; $display("FAIL bp_addr: got %h expected %h", addr, BASE0 + 64'h80); end
    n_checks++; if (head !== 32'd3) begin n_fail++; $display("FAIL bp_head: got %0d expected 3", head); end
    n_checks++; if (data !== exp) begin n_fail++; $display("FAIL bp_data: got %h expected %h", data, exp); end
    n_checks++; if (sq_empty !== 2'b11) begin n_fail++; $display("FAIL bp_empty: got %b expected 11", sq_empty); end
  endtask

  task automatic test_same_cycle;
    logic ack, err, ok, stable;
    logic [63:0] addr; logic [31:0] id, head; logic [511:0] data;
    int waited;
    doorbell(0, 4, ack, err);
    waited = 0;
    while (!sq_read_req && waited < 20) begin @(negedge clk); waited++; end
    n_checks++; if (sq_read_req !== 1'b1 || sq_read_addr !== BASE0 + 64'hC0) begin n_fail++; $display("FAIL same_req: got req %b addr %h expected 1 %h", sq_read_req, sq_read_addr, BASE0 + 64'hC0); end
    sq_read_ack = 1'b1;
    @(negedge clk); sq_read_ack = 1'b0;
    sq_rdata_valid = 1'b1; sq_rdata = {16{32'h5A5A_0004}};
    @(negedge clk); sq_rdata_valid = 1'b0;
    n_checks++; if (cmd_valid !== 1'b1 || cmd_sq_head !== 32'd4) begin n_fail++; $display("FAIL same_cmd: got valid %b head %0d expected 1 4", cmd_valid, cmd_sq_head); end
    cmd_ready = 1'b1;
    sq_dbell_valid = 1'b1; sq_dbell_id = 32'd0; sq_dbell_ptr = 32'd5;
    @(negedge clk);
    cmd_ready = 1'b0; sq_dbell_valid = 1'b0;
    n_checks++; if (sq_dbell_ack !== 1'b1) begin n_fail++; $display("FAIL same_ack: got %b expected 1", sq_dbell_ack); end
    serve(0, 0, {16{32'h5A5A_0005}}, addr, id, data, head, waited, stable, ok);
    n_checks++; if (ok !== 1'b1 || addr !== BASE0 + 64'h100 || head !== 32'd5) begin n_fail++; $display("FAIL same_both_applied: got ok %b addr %h head %0d expected 1 %h 5", ok, addr, head, BASE0 + 64'h100); end
    n_checks++; if (sq_empty !== 2'b11) begin n_fail++; $display("FAIL same_empty: got %b expected 11", sq_empty); end
  endtask

  task automatic test_disable_inflight;
    logic ack, err, ok, stable;
    logic [63:0] addr; logic [31:0] id, head; logic [511:0] data, pay;
    int waited;
    pay = {16{32'hD15A_B1ED}};
    doorbell(1, 4, ack, err);
    waited = 0;
    while (!sq_read_req && waited < 20) begin @(negedge clk); waited++; end
    n_checks++; if (sq_read_id !== 32'd1 || sq_read_addr !== 64'h80) begin n_fail++; $display("FAIL dis_req: got id %0d addr %h expected 1 0000000000000080", sq_read_id, sq_read_addr); end
    sq_read_ack = 1'b1;
    @(negedge clk); sq_read_ack = 1'b0;
    sq_enable = 2'b01;
    sq_rdata_valid = 1'b1; sq_rdata = pay;
    @(negedge clk); sq_rdata_valid = 1'b0;
    n_checks++; if (cmd_valid !== 1'b1 || cmd_sq_id !== 32'd1 || cmd_data !== pay) begin n_fail++; $display("FAIL dis_delivered: got valid %b id %0d data %h expected 1 1 %h", cmd_valid, cmd_sq_id, cmd_data, pay); end
    cmd_ready = 1'b1;
    @(negedge clk); cmd_ready = 1'b0;
    n_checks++; if (cmd_valid !== 1'b0 || sq_empty[1] !== 1'b1) begin n_fail++; $display("FAIL dis_done: got valid %b empty1 %b expected 0 1", cmd_valid, sq_empty[1]); end
    sq_enable = 2'b11;
    doorbell(1, 1, ack, err);
    serve(0, 0, pay, addr, id, data, head, waited, stable, ok);
    n_checks++; if (ok !== 1'b1 || addr !== BASE1 || head !== 32'd1) begin n_fail++; $display("FAIL dis_head_zero: got ok %b addr %h head %0d expected 1 %h 1", ok, addr, head, BASE1); end
  endtask

  task automatic test_reset_midfetch;
    logic ack, err, ok, stable, quiet;
    logic [63:0] addr; logic [31:0] id, head; logic [511:0] data;
    int waited;
    doorbell(0, 6, ack, err);
    waited = 0;
    while (!sq_read_req && waited < 20) begin @(negedge clk); waited++; end
    sq_read_ack = 1'b1;
    @(negedge clk); sq_read_ack = 1'b0;
    n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rst_in_wait: got state %0d expected 2", dbg_state); end
    reset = 1'b1;
    #1;
    n_checks++; if (dbg_state !== 2'd0 || sq_read_addr !== 64'h0 || sq_empty !== 2'b11) begin n_fail++; $display("FAIL rst_async_clear: got state %0d addr %h empty %b expected 0 0 11", dbg_state, sq_read_addr, sq_empty); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    sq_rdata_valid = 1'b1; sq_rdata = {16{32'h1A7E_1A7E}};
    @(negedge clk); sq_rdata_valid = 1'b0; sq_rdata = '0;
    quiet = 1'b1;
    repeat (6) begin
      if (cmd_valid || sq_read_req) quiet = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (quiet !== 1'b1 || sq_empty !== 2'b11) begin n_fail++; $display("FAIL rst_late_rdata: got quiet %b empty %b expected 1 11", quiet, sq_empty); end
    doorbell(0, 1, ack, err);
    serve(0, 0, {16{32'h0000_0001}}, addr, id, data, head, waited, stable, ok);
    n_checks++; if (ok !== 1'b1 || addr !== BASE0 || head !== 32'd1) begin n_fail++; $display("FAIL rst_heads_zero: got ok %b addr %h head %0d expected 1 %h 1", ok, addr, head, BASE0); end
  endtask

  initial begin
    reset          = 1'b1;
    sq_enable      = 2'b11;
    sq_base        = {BASE1, BASE0};
    sq_dbell_valid = 1'b0;
    sq_dbell_id    = '0;
    sq_dbell_ptr   = '0;
    sq_read_ack    = 1'b0;
    sq_rdata_valid = 1'b0;
    sq_rdata       = '0;
    cmd_ready      = 1'b0;
    test_reset();
    test_single_queue();
    test_wrap();
    test_round_robin();
    test_bad_doorbells();
    test_back_to_back();
    test_backpressure();
    test_same_cycle();
    test_disable_inflight();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
